mic_capture_ctrl: RTL and testbench

//  Sequences capture of stereo I2S frames from i2s_capture_24 into an on-chip snapshot buffer.

---
 rtl/mic_capture_ctrl_pkg.sv | 19 +
 rtl/mic_capture_ctrl_buf.sv | 36 +++
 rtl/mic_capture_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mic_capture_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mic_capture_ctrl_pkg.sv
// Shared types and constants for the microphone snapshot capture block.
package mic_capture_ctrl_pkg;

    localparam int CAP_DEPTH    = 256;
    localparam int CAP_SAMPLE_W = 24;

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_ARMED   = 2'd1,
        CAP_CAPTURE = 2'd2,
        CAP_DONE    = 2'd3
    } cap_state_t;

    typedef struct packed {
        logic [CAP_SAMPLE_W-1:0] left;
        logic [CAP_SAMPLE_W-1:0] right;
    } cap_entry_t;

endpackage

// File: rtl/mic_capture_ctrl_buf.sv
// Single-port snapshot buffer: one access per cycle, write or registered read.
// The read register is the only output and keeps its value between reads.
module capture_buf_sp
    import mic_capture_ctrl_pkg::*;
#(
    parameter int DATA_W = 2 * CAP_SAMPLE_W,
    parameter int ADDR_W = $clog2(CAP_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write port: storage array, no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read port: registered output, cleared by reset, held when not reading.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mic_capture_ctrl.sv
// Snapshot capture sequencer: arms on start, decimates incoming stereo frames,
// writes them into a single-port buffer and shares that buffer with a readout
// port. Pending capture writes always take the buffer ahead of reads.
module mic_capture_ctrl
    import mic_capture_ctrl_pkg::*;
#(
    parameter  int SAMPLE_W = 24,
    parameter  int DEPTH    = CAP_DEPTH,
    parameter  int DECIM_W  = 8,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_W:0]       frames_i,
    input  logic [DECIM_W-1:0]    decim_i,
    input  logic                  sample_stb_i,
    input  logic [SAMPLE_W-1:0]   left_i,
    input  logic [SAMPLE_W-1:0]   right_i,
    input  logic                  rd_req_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic                  rd_gnt_o,
    output logic                  rd_valid_o,
    output logic [2*SAMPLE_W-1:0] rd_data_o,
    output logic [1:0]            state_o,
    output logic [ADDR_W:0]       count_o,
    output logic                  done_o,
    output logic                  start_ign_o
);

    localparam logic [ADDR_W:0]  FRAMES_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]  FRAMES_ONE = (ADDR_W+1)'(1);
    localparam logic [DECIM_W-1:0] DECIM_ONE = DECIM_W'(1);

    // A requested length of zero, or one beyond the buffer, means "fill it".
    function automatic logic [ADDR_W:0] sat_frames(input logic [ADDR_W:0] f);
        if (f == '0 || f > FRAMES_MAX) begin
            return FRAMES_MAX;
        end
        return f;
    endfunction

    cap_state_t            state, state_nxt;
    logic [ADDR_W:0]       frames_lat;
    logic [DECIM_W-1:0]    decim_lat;
    logic [DECIM_W-1:0]    decim_cnt;
    logic [ADDR_W:0]       count_q;
    logic                  start_ign_q;

    logic                  accept_start;
    logic                  ign_set;
    logic                  wr_fire;
    logic                  decim_step;

    logic                  wr_vld_p1;
    logic [ADDR_W-1:0]     wr_addr_p1;
    logic [2*SAMPLE_W-1:0] wr_data_p1;
    logic                  rd_gnt;
    logic                  rd_vld_p1;

    logic                  buf_en;
    logic [ADDR_W-1:0]     buf_addr;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= CAP_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle control strobes; abort outranks start everywhere.
    always_comb begin
        state_nxt    = state;
        accept_start = 1'b0;
        ign_set      = 1'b0;
        wr_fire      = 1'b0;
        decim_step   = 1'b0;
        unique case (state)
            CAP_IDLE: begin
                if (start_i && !abort_i) begin
                    accept_start = 1'b1;
                    state_nxt    = CAP_ARMED;
                end
            end
            CAP_ARMED: begin
                if (abort_i) begin
                    state_nxt = CAP_IDLE;
                end else begin
                    ign_set = start_i;
                    if (sample_stb_i) begin
                        wr_fire   = 1'b1;
                        state_nxt = (frames_lat == FRAMES_ONE) ? CAP_DONE : CAP_CAPTURE;
                    end
                end
            end
            CAP_CAPTURE: begin
                if (abort_i) begin
                    state_nxt = CAP_IDLE;
                end else begin
                    ign_set = start_i;
                    if (sample_stb_i) begin
                        if (decim_cnt == decim_lat) begin
                            wr_fire = 1'b1;
                            if (count_q + FRAMES_ONE == frames_lat) begin
                                state_nxt = CAP_DONE;
                            end
                        end else begin
                            decim_step = 1'b1;
                        end
                    end
                end
            end
            CAP_DONE: begin
                if (abort_i) begin
                    state_nxt = CAP_IDLE;
                end else if (start_i) begin
                    accept_start = 1'b1;
                    state_nxt    = CAP_ARMED;
                end
            end
            default: state_nxt = CAP_IDLE;
        endcase
    end

    // Capture configuration, entry counter, decimator and sticky flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frames_lat  <= '0;
            decim_lat   <= '0;
            decim_cnt   <= '0;
            count_q     <= '0;
            start_ign_q <= 1'b0;
        end else if (accept_start) begin
            frames_lat  <= sat_frames(frames_i);
            decim_lat   <= decim_i;
            decim_cnt   <= '0;
            count_q     <= '0;
            start_ign_q <= 1'b0;
        end else begin
            if (ign_set) begin
                start_ign_q <= 1'b1;
            end
            if (wr_fire) begin
                count_q   <= count_q + FRAMES_ONE;
                decim_cnt <= '0;
            end else if (decim_step) begin
                decim_cnt <= decim_cnt + DECIM_ONE;
            end
        end
    end

    // Stage p0 -> p1: write request and read grant registered for the buffer cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_vld_p1 <= 1'b0;
            rd_vld_p1 <= 1'b0;
        end else begin
            wr_vld_p1 <= wr_fire;
            rd_vld_p1 <= rd_gnt;
        end
    end

    // Write payload travels with wr_vld_p1; count_q is still the pre-increment index here.
    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            wr_addr_p1 <= count_q[ADDR_W-1:0];
            wr_data_p1 <= {left_i, right_i};
        end
    end

    assign rd_gnt   = rd_req_i & ~wr_vld_p1;
    assign buf_en   = wr_vld_p1 | rd_gnt;
    assign buf_addr = wr_vld_p1 ? wr_addr_p1 : rd_addr_i;

    capture_buf_sp #(
        .DATA_W (2 * SAMPLE_W),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk   (clk_i),
        .rst   (rst_i),
        .en    (buf_en),
        .we    (wr_vld_p1),
        .addr  (buf_addr),
        .wdata (wr_data_p1),
        .rdata (rd_data_o)
    );

    assign rd_gnt_o    = rd_gnt;
    assign rd_valid_o  = rd_vld_p1;
    assign state_o     = state;
    assign count_o     = count_q;
    assign done_o      = (state == CAP_DONE);
    assign start_ign_o = start_ign_q;

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// Bench for mic_capture_ctrl: vector table, directed corner sequences and a
// randomized run against a frame-level reference model.
module tb_mic_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1, start_i = 1'b0, abort_i = 1'b0;
    logic [8:0]  frames_i = '0;
    logic [7:0]  decim_i = '0;
    logic        sample_stb_i = 1'b0;
    logic [23:0] left_i = '0, right_i = '0;
    logic        rd_req_i = 1'b0;
    logic [7:0]  rd_addr_i = '0;
    logic        rd_gnt_o, rd_valid_o, done_o, start_ign_o;
    logic [47:0] rd_data_o;
    logic [1:0]  state_o;
    logic [8:0]  count_o;

    always #5 clk = ~clk;

    mic_capture_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .frames_i(frames_i), .decim_i(decim_i), .sample_stb_i(sample_stb_i),
        .left_i(left_i), .right_i(right_i), .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i),
        .rd_gnt_o(rd_gnt_o), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
        .state_o(state_o), .count_o(count_o), .done_o(done_o), .start_ign_o(start_ign_o)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rst_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; sample_stb_i = 1'b0; rd_req_i = 1'b0;
    endtask

    task automatic do_reset();
        clr(); rst_i = 1'b1; tick(); rst_i = 1'b0;
    endtask

    task automatic do_start(input int f, input int d);
        start_i = 1'b1; frames_i = f[8:0]; decim_i = d[7:0]; tick(); start_i = 1'b0;
    endtask

    task automatic strobe(input logic [23:0] l, input logic [23:0] r);
        sample_stb_i = 1'b1; left_i = l; right_i = r; tick();
        sample_stb_i = 1'b0; tick();
    endtask

    task automatic read_chk(input logic [7:0] a, input logic [47:0] exp, input string nm);
        int w;
        rd_req_i = 1'b1; rd_addr_i = a; w = 0;
        #1;
        while (!rd_gnt_o && w < 4) begin
            tick(); w++;
        end
        chk({nm, " gnt"}, rd_gnt_o, 1);
        tick();
        rd_req_i = 1'b0;
        chk({nm, " valid"}, rd_valid_o, 1);
        chk({nm, " data"}, rd_data_o, exp);
    endtask

    typedef struct {
        logic rst, start, abort, stb;
        logic [8:0] frames;
        logic [7:0] decim;
        logic [1:0] st;
        logic [8:0] cnt;
        logic done, ign;
    } vec_t;

    function automatic vec_t mk(input int r, input int s, input int a, input int b, input int f,
                                input int st, input int c, input int dn, input int ig);
        vec_t v;
        v.rst = r[0]; v.start = s[0]; v.abort = a[0]; v.stb = b[0];
        v.frames = f[8:0]; v.decim = 8'd0;
        v.st = st[1:0]; v.cnt = c[8:0]; v.done = dn[0]; v.ign = ig[0];
        return v;
    endfunction

    // Reference model state: frame-level view of one capture.
    int          m_mode, m_frames, m_decim, m_count, m_n;
    bit          m_ign, m_pend, m_rdv, m_rdk;
    int          m_paddr;
    logic [47:0] m_pdata, m_rdd;
    logic [47:0] m_mem [256];
    bit          m_known [256];

    task automatic m_step(input bit rst, input bit st, input bit ab, input bit stb, input int f,
                          input int d, input logic [47:0] din, input bit rq, input int ra);
        bit gnt;
        gnt = rq && !m_pend;
        if (m_pend) begin
            m_mem[m_paddr] = m_pdata; m_known[m_paddr] = 1'b1; m_pend = 1'b0;
        end
        if (rst) begin
            m_mode = 0; m_count = 0; m_ign = 1'b0; m_rdv = 1'b0; m_rdd = '0; m_rdk = 1'b1;
            return;
        end
        m_rdv = gnt;
        if (gnt) begin
            m_rdd = m_mem[ra]; m_rdk = m_known[ra];
        end
        if (ab) begin
            m_mode = 0;
            return;
        end
        if (st && (m_mode == 0 || m_mode == 3)) begin
            m_frames = (f == 0 || f > 256) ? 256 : f;
            m_decim = d; m_count = 0; m_ign = 1'b0; m_n = 0; m_mode = 1;
            return;
        end
        if (st) m_ign = 1'b1;
        if (stb && (m_mode == 1 || m_mode == 2)) begin
            if (m_n % (m_decim + 1) == 0) begin
                m_pend = 1'b1; m_paddr = m_count; m_pdata = din;
                m_count++;
                m_mode = (m_count == m_frames) ? 3 : 2;
            end
            m_n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[20];
        tbl[0]  = mk(1,0,0,0,4, 0,0,0,0);
        tbl[1]  = mk(0,1,0,0,4, 1,0,0,0);
        tbl[2]  = mk(0,0,0,0,4, 1,0,0,0);
        tbl[3]  = mk(0,0,0,1,4, 2,1,0,0);
        tbl[4]  = mk(0,0,0,0,4, 2,1,0,0);
        tbl[5]  = mk(0,0,0,1,4, 2,2,0,0);
        tbl[6]  = mk(0,0,0,0,4, 2,2,0,0);
        tbl[7]  = mk(0,0,0,1,4, 2,3,0,0);
        tbl[8]  = mk(0,0,0,0,4, 2,3,0,0);
        tbl[9]  = mk(0,0,0,1,4, 3,4,1,0);
        tbl[10] = mk(0,0,0,0,4, 3,4,1,0);
        tbl[11] = mk(0,1,0,0,1, 1,0,0,0);
        tbl[12] = mk(0,0,0,1,1, 3,1,1,0);
        tbl[13] = mk(0,1,1,0,2, 0,1,0,0);
        tbl[14] = mk(0,1,0,0,2, 1,0,0,0);
        tbl[15] = mk(0,1,0,0,2, 1,0,0,1);
        tbl[16] = mk(0,0,0,1,2, 2,1,0,1);
        tbl[17] = mk(0,0,1,0,2, 0,1,0,1);
        tbl[18] = mk(0,1,0,0,2, 1,0,0,0);
        tbl[19] = mk(1,0,0,0,2, 0,0,0,0);

        // Vector table.
        for (int i = 0; i < 20; i++) begin
            rst_i = tbl[i].rst; start_i = tbl[i].start; abort_i = tbl[i].abort;
            sample_stb_i = tbl[i].stb; frames_i = tbl[i].frames; decim_i = tbl[i].decim;
            left_i = 24'(i); right_i = 24'(i + 100);
            tick();
            clr();
            chk($sformatf("vec%0d state", i), state_o, tbl[i].st);
            chk($sformatf("vec%0d count", i), count_o, tbl[i].cnt);
            chk($sformatf("vec%0d done", i), done_o, tbl[i].done);
            chk($sformatf("vec%0d ign", i), start_ign_o, tbl[i].ign);
        end

        // Decimation: frames=3, decim=2 keeps strobes 0, 3 and 6.
        do_reset();
        do_start(3, 2);
        for (int k = 0; k < 9; k++) begin
            strobe(24'(32'h100 + k), 24'(32'hABC000 + k));
            if (k == 5) begin
                chk("decim before 7th state", state_o, 2);
                chk("decim before 7th count", count_o, 2);
            end
            if (k == 6) begin
                chk("decim 7th state", state_o, 3);
                chk("decim 7th count", count_o, 3);
            end
        end
        chk("decim end state", state_o, 3);
        chk("decim end count", count_o, 3);
        read_chk(8'd0, {24'h000100, 24'hABC000}, "decim rd0");
        read_chk(8'd1, {24'h000103, 24'hABC003}, "decim rd1");
        read_chk(8'd2, {24'h000106, 24'hABC006}, "decim rd2");

        // Read colliding with the registered write of the strobe just taken.
        do_reset();
        do_start(8, 0);
        sample_stb_i = 1'b1; left_i = 24'h5A5A5A; right_i = 24'hA5A5A5;
        tick();
        sample_stb_i = 1'b0; rd_req_i = 1'b1; rd_addr_i = 8'd0;
        #1;
        chk("collide gnt stalled", rd_gnt_o, 0);
        tick();
        chk("collide gnt next", rd_gnt_o, 1);
        tick();
        rd_req_i = 1'b0;
        chk("collide valid", rd_valid_o, 1);
        chk("collide data", rd_data_o, {24'h5A5A5A, 24'hA5A5A5});
        tick();
        chk("collide valid drop", rd_valid_o, 0);
        chk("collide data hold", rd_data_o, {24'h5A5A5A, 24'hA5A5A5});

        // start mid-capture is ignored, abort keeps the count.
        start_i = 1'b1; frames_i = 9'd2; tick(); start_i = 1'b0;
        chk("ign flag", start_ign_o, 1);
        chk("ign state", state_o, 2);
        chk("ign count", count_o, 1);
        strobe(24'h1, 24'h2);
        chk("ign capture count", count_o, 2);
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        chk("abort state", state_o, 0);
        chk("abort count", count_o, 2);
        chk("abort done", done_o, 0);

        // frames_i=0 fills the whole buffer.
        do_start(0, 0);
        for (int k = 0; k < 256; k++) begin
            strobe(24'(k), 24'(k) ^ 24'hFFFFFF);
            if (k == 254) begin
                chk("full 255 state", state_o, 2);
                chk("full 255 count", count_o, 255);
            end
        end
        chk("full state", state_o, 3);
        chk("full count", count_o, 256);
        chk("full done", done_o, 1);
        read_chk(8'd255, {24'h0000FF, 24'hFFFF00}, "full rd255");
        read_chk(8'd7, {24'h000007, 24'hFFFFF8}, "full rd7");

        // Reset in the middle of a capture.
        do_start(0, 1);
        strobe(24'h11, 24'h22); strobe(24'h33, 24'h44); strobe(24'h55, 24'h66);
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        chk("rst state", state_o, 0);
        chk("rst count", count_o, 0);
        chk("rst done", done_o, 0);
        chk("rst ign", start_ign_o, 0);
        chk("rst valid", rd_valid_o, 0);
        chk("rst data", rd_data_o, 0);
        chk("rst gnt", rd_gnt_o, 0);

        // Randomized run against the reference model.
        begin
            bit          req_act;
            bit          exp_gnt;
            logic [7:0]  raddr;
            int          gap, r, f, d;
            req_act = 1'b0; raddr = '0; gap = 5;
            m_pend = 1'b0; m_mode = 0; m_frames = 256; m_decim = 0; m_n = 0;
            for (int a = 0; a < 256; a++) m_known[a] = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                clr();
                rst_i = (c == 0) || ($urandom_range(0, 699) == 0);
                r = $urandom_range(0, 199);
                f = $urandom_range(0, 511);
                d = $urandom_range(0, 3);
                if (r < 1) begin
                    abort_i = 1'b1;
                end else if (r < 4) begin
                    start_i = 1'b1;
                    case ($urandom_range(0, 5))
                        0: f = 0;
                        1: f = 1;
                        2: f = 2;
                        3: f = 300;
                        default: f = $urandom_range(3, 12);
                    endcase
                end
                frames_i = f[8:0]; decim_i = d[7:0];
                if (gap >= 1 && $urandom_range(0, 2) == 0) begin
                    sample_stb_i = 1'b1; left_i = 24'($urandom); right_i = 24'($urandom); gap = 0;
                end else begin
                    gap++;
                end
                if (!req_act && $urandom_range(0, 3) == 0) begin
                    req_act = 1'b1; raddr = 8'($urandom_range(0, 15));
                end
                rd_req_i = req_act; rd_addr_i = raddr;
                #1;
                exp_gnt = req_act && !m_pend;
                chk("rand gnt", rd_gnt_o, exp_gnt);
                m_step(rst_i, start_i, abort_i, sample_stb_i, f, d, {left_i, right_i}, req_act, int'(raddr));
                tick();
                if (exp_gnt) req_act = 1'b0;
                chk("rand state", state_o, m_mode);
                chk("rand count", count_o, m_count);
                chk("rand done", done_o, m_mode == 3);
                chk("rand ign", start_ign_o, m_ign);
                chk("rand valid", rd_valid_o, m_rdv);
                if (m_rdk) chk("rand data", rd_data_o, m_rdd);
            end
        end

        clr();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
